// File: rtl/ram_2p_init_if.sv
// ram_2p_init_if
//   Request/response bundle for the ram_2p_init dual-port SRAM.
//   master : drives clear/write/read requests, receives read data and busy.
//   slave  : the SRAM side.
// Signals
//   i_clear          restart zero-init (pulse)
//   i_wen/i_waddr/i_wdata/i_wmask   write port, byte-masked
//   i_ren/i_raddr    read port
//   o_rdata/o_rvalid read response
//   o_busy           zero-init running, requests ignored
interface ram_2p_init_if #(
  parameter int ADR_W  = 10,
  parameter int SRAM_W = 128
);
  logic                  i_clear;
  logic                  i_wen;
  logic [ADR_W-1:0]      i_waddr;
  logic [SRAM_W-1:0]     i_wdata;
  logic [SRAM_W/8-1:0]   i_wmask;
  logic                  i_ren;
  logic [ADR_W-1:0]      i_raddr;
  logic [SRAM_W-1:0]     o_rdata;
  logic                  o_rvalid;
  logic                  o_busy;

  modport master (
    output i_clear, i_wen, i_waddr, i_wdata, i_wmask, i_ren, i_raddr,
    input  o_rdata, o_rvalid, o_busy
  );

  modport slave (
    input  i_clear, i_wen, i_waddr, i_wdata, i_wmask, i_ren, i_raddr,
    output o_rdata, o_rvalid, o_busy
  );
endinterface

// File: rtl/ram_2p_init.sv
// ram_2p_init
//   Simple dual-port inferred SRAM: one byte-masked write port, one read port,
//   single clock. Read latency RD_LAT (1..4), optional same-address
//   write-to-read forwarding, and a zero-init sequencer that clears the array
//   one word per cycle after reset or on i_clear.
// Ports
//   i_clk   clock
//   i_rstn  synchronous active-low reset
//   bus     ram_2p_init_if.slave (clear, write, read request; rdata/rvalid/busy)
// Parameters
//   ADR_W   address width, depth = 2**ADR_W
//   SRAM_W  word width, multiple of 8
//   RD_LAT  read latency in cycles, 1..4
//   FWD     1: colliding read returns merged new data, 0: old data
module ram_2p_init #(
  parameter int ADR_W  = 10,
  parameter int SRAM_W = 128,
  parameter int RD_LAT = 1,
  parameter int FWD    = 1
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  ram_2p_init_if.slave  bus
);
  localparam int NB     = SRAM_W / 8;
  localparam int DEPTH  = 1 << ADR_W;
  localparam int STAGES = RD_LAT - 1;

  typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} st_e;

  st_e                       r_st, w_st_nxt;
  logic [ADR_W-1:0]          r_cnt, w_cnt_nxt;
  logic                      w_busy;

  logic                      w_ready, w_wr_go, w_rd_go;
  logic                      w_mem_we;
  logic [ADR_W-1:0]          w_mem_addr;
  logic [NB-1:0]             w_mem_mask;
  logic [SRAM_W-1:0]         w_mem_data;
  logic [SRAM_W-1:0]         w_old, w_rword;

  logic [SRAM_W-1:0]         r_mem [DEPTH];
  logic [STAGES:0]           vld_pipe;
  logic [STAGES:0][SRAM_W-1:0] r_dat;

  // ---------------- zero-init sequencer ----------------
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_st  <= ST_INIT;
      r_cnt <= '0;
    end else begin
      r_st  <= w_st_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  // Counter wraps to 0 on the last INIT word, so a later clear starts at 0
  // without an explicit reload.
  always_comb begin
    w_st_nxt  = r_st;
    w_cnt_nxt = r_cnt;
    w_busy    = 1'b1;
    case (r_st)
      ST_INIT: begin
        w_cnt_nxt = r_cnt + ADR_W'(1);
        if (r_cnt == {ADR_W{1'b1}}) w_st_nxt = ST_READY;
      end
      ST_READY: begin
        w_busy = 1'b0;
        if (bus.i_clear) w_st_nxt = ST_INIT;
      end
      default: w_st_nxt = ST_INIT;
    endcase
  end

  assign w_ready = (r_st == ST_READY);
  // A clear in the same cycle as a write wins: the write is dropped.
  assign w_wr_go = w_ready & bus.i_wen & ~bus.i_clear;
  assign w_rd_go = w_ready & bus.i_ren;

  // ---------------- array write port ----------------
  // INIT borrows the write port with a full mask and zero data.
  assign w_mem_we   = i_rstn & (~w_ready | w_wr_go);
  assign w_mem_addr = w_ready ? bus.i_waddr : r_cnt;
  assign w_mem_mask = w_ready ? bus.i_wmask : {NB{1'b1}};
  assign w_mem_data = w_ready ? bus.i_wdata : '0;

  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (w_mem_mask[b]) r_mem[w_mem_addr][8*b +: 8] <= w_mem_data[8*b +: 8];
      end
    end
  end

  // ---------------- read port ----------------
  assign w_old = r_mem[bus.i_raddr];

  // Forwarding merges only the bytes the accepted write actually changes.
  always_comb begin
    w_rword = w_old;
    if (FWD != 0 && w_wr_go && (bus.i_raddr == bus.i_waddr)) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.i_wmask[b]) w_rword[8*b +: 8] = bus.i_wdata[8*b +: 8];
      end
    end
  end

  // Data stages load only behind a valid bit, so the last stage holds its
  // value while o_rvalid is low. In-flight reads keep draining during INIT.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      vld_pipe <= '0;
      r_dat    <= '0;
    end else begin
      vld_pipe[0] <= w_rd_go;
      if (w_rd_go) r_dat[0] <= w_rword;
      for (int k = 1; k <= STAGES; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        if (vld_pipe[k-1]) r_dat[k] <= r_dat[k-1];
      end
    end
  end

  assign bus.o_rvalid = vld_pipe[STAGES];
  assign bus.o_rdata  = r_dat[STAGES];
  assign bus.o_busy   = w_busy;

endmodule
